// File: rtl/out_buffer_pkg.sv
// out_buffer_pkg
//   Shared types, constants and arithmetic helpers for the output buffer.
//   Contents:
//     state_e         - buffer FSM states (IDLE, ACCUM, DRAIN)
//     LANES           - partial-sum lanes per PE word
//     FRAME_WORDS_DEF - default number of words in one frame
//     PIX_W           - width of one output pixel
//     satAdd          - signed add that saturates to a given width
//     reluShiftClamp  - ReLU, right shift, then clamp to an unsigned pixel
package out_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int LANES           = 4;
  localparam int FRAME_WORDS_DEF = 768;
  localparam int PIX_W           = 8;

  // Adds two signed values and clamps the result to the signed range of a
  // w-bit number. The 33-bit intermediate cannot overflow for w <= 32, and
  // every clamped result fits in 32 bits, so the caller just truncates to w.
  function automatic logic signed [31:0] satAdd(input logic signed [31:0] a,
                                                input logic signed [31:0] b,
                                                input int w);
    logic signed [32:0] sum;
    logic signed [32:0] maxV;
    logic signed [32:0] minV;
    sum  = 33'(a) + 33'(b);
    maxV = (33'sd1 <<< (w - 1)) - 33'sd1;
    minV = -(33'sd1 <<< (w - 1));
    if (sum > maxV) begin
      return maxV[31:0];
    end else if (sum < minV) begin
      return minV[31:0];
    end
    return sum[31:0];
  endfunction

  // Turns an accumulated partial sum into an output pixel: negatives become
  // zero, positives are scaled down by sh bits and clamped to the pixel range.
  function automatic logic [PIX_W-1:0] reluShiftClamp(input logic signed [31:0] s,
                                                      input int sh);
    logic [31:0] mag;
    if (s < 0) begin
      mag = '0;
    end else begin
      mag = $unsigned(s) >> sh;
    end
    if (mag > ((32'd1 << PIX_W) - 32'd1)) begin
      return '1;
    end
    return mag[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/out_buffer_ram.sv
// psum_ram
//   Simple dual-port synchronous RAM holding one frame of partial sums.
//   One write port and one read port; the read data is registered, so it
//   appears the cycle after the address is presented.
//   Ports:
//     clk       - clock
//     wrEn_i    - write enable
//     wrAddr_i  - write address
//     wrData_i  - write data
//     rdAddr_i  - read address
//     rdData_o  - registered read data (1-cycle latency)
module psum_ram
  import out_buffer_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = LANES * 16
) (
  input  logic              clk,
  input  logic              wrEn_i,
  input  logic [ADDR_W-1:0] wrAddr_i,
  input  logic [DATA_W-1:0] wrData_i,
  input  logic [ADDR_W-1:0] rdAddr_i,
  output logic [DATA_W-1:0] rdData_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdData_q;

  // Both ports work on the same edge. The accumulate pipeline never reads
  // and writes the same address in one cycle, so the read-during-write
  // behaviour of the array does not matter here.
  always_ff @(posedge clk) begin
    if (wrEn_i) begin
      mem[wrAddr_i] <= wrData_i;
    end
    rdData_q <= mem[rdAddr_i];
  end

  assign rdData_o = rdData_q;

endmodule

// File: rtl/out_buffer.sv
// out_buffer
//   Collects the PE array's 4-lane partial sums over one frame, accumulates
//   them across input channels in an on-chip psum RAM, and after the last
//   input channel streams the frame out as 8-bit pixels over AXI-Stream.
//   Ports:
//     clk, rst        - clock and synchronous active-high reset
//     i_pe_valid      - one PE word this cycle (no backpressure)
//     i_pe_data       - lanes 3..0 of signed partial sums
//     i_first_ic      - with a frame's first word: overwrite instead of add
//     i_last_ic       - with a frame's first word: drain after this frame
//     m_axis_*        - AXI-Stream master towards the DMA S2MM port
//     o_busy          - FSM is not idle
//     o_done          - one-cycle pulse after the final beat handshakes
//     o_overflow      - sticky: a PE word arrived while draining
module out_buffer
  import out_buffer_pkg::*;
#(
  parameter int FRAME_WORDS = FRAME_WORDS_DEF,
  parameter int ADDR_W      = 10,
  parameter int PSUM_W      = 16,
  parameter int OUT_SHIFT   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_pe_valid,
  input  logic [LANES*PSUM_W-1:0] i_pe_data,
  input  logic                    i_first_ic,
  input  logic                    i_last_ic,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [LANES*PIX_W-1:0]  m_axis_tdata,
  output logic [3:0]              m_axis_tstrb,
  output logic                    m_axis_tlast,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_overflow
);

  localparam int DATA_W = LANES * PSUM_W;
  localparam int OUT_W  = LANES * PIX_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] wordCnt_q;
  logic [ADDR_W-1:0] rdAddr_q;
  logic [ADDR_W-1:0] beatCnt_q;
  logic              first_q;
  logic              last_q;
  logic              rdDone_q;
  logic              done_q;
  logic              overflow_q;

  logic              s1Valid_q;
  logic              s1First_q;
  logic [DATA_W-1:0] s1Data_q;
  logic [ADDR_W-1:0] s1Addr_q;

  logic              wrEn_q;
  logic [ADDR_W-1:0] wrAddr_q;
  logic [DATA_W-1:0] wrData_q;
  logic [DATA_W-1:0] wrData_d;

  logic [ADDR_W-1:0] ramRdAddr;
  logic [DATA_W-1:0] ramRdData;

  logic              rdPend_q;
  logic [1:0]        occ_q;
  logic [1:0]        occ_d;
  logic [OUT_W-1:0]  skid0_q;
  logic [OUT_W-1:0]  skid1_q;
  logic [OUT_W-1:0]  skid0_d;
  logic [OUT_W-1:0]  skid1_d;
  logic [OUT_W-1:0]  pushData;

  logic              accept;
  logic              readIssue;
  logic              pop;
  logic              push;

  // Words arriving while draining are dropped (and flagged as overflow).
  assign accept = i_pe_valid && (state_q != DRAIN);
  assign pop    = (occ_q != 2'd0) && m_axis_tready;
  assign push   = rdPend_q;

  // A drain read is only issued when its data is guaranteed a skid slot when
  // it lands next cycle: entries held plus the read in flight, minus the
  // beat leaving now, must leave at least one slot free.
  assign readIssue = (state_q == DRAIN) && !rdDone_q &&
                     ((int'(occ_q) + int'(rdPend_q) - int'(pop)) <= 1);

  // The single read port serves the accumulate lookup outside DRAIN and the
  // sequential drain scan inside it.
  assign ramRdAddr = (state_q == DRAIN) ? rdAddr_q : wordCnt_q;

  psum_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_psum_ram (
    .clk      (clk),
    .wrEn_i   (wrEn_q),
    .wrAddr_i (wrAddr_q),
    .wrData_i (wrData_q),
    .rdAddr_i (ramRdAddr),
    .rdData_o (ramRdData)
  );

  // Main FSM plus its counters and status flags. The first word of a frame
  // is accepted straight from IDLE, so the channel flags are latched there.
  // Drain bookkeeping (read address, beat count) is cleared on the way into
  // DRAIN so an aborted or finished drain leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wordCnt_q  <= '0;
      rdAddr_q   <= '0;
      beatCnt_q  <= '0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      rdDone_q   <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (i_pe_valid && (state_q == DRAIN)) begin
        overflow_q <= 1'b1;
      end
      if (pop) begin
        beatCnt_q <= beatCnt_q + 1'b1;
      end
      if (readIssue) begin
        rdAddr_q <= rdAddr_q + 1'b1;
        if (rdAddr_q == LAST_ADDR) begin
          rdDone_q <= 1'b1;
        end
      end
      case (state_q)
        IDLE: begin
          if (i_pe_valid) begin
            first_q   <= i_first_ic;
            last_q    <= i_last_ic;
            wordCnt_q <= wordCnt_q + 1'b1;
            state_q   <= ACCUM;
          end
        end
        ACCUM: begin
          if (i_pe_valid) begin
            if (wordCnt_q == LAST_ADDR) begin
              wordCnt_q <= '0;
              rdAddr_q  <= '0;
              rdDone_q  <= 1'b0;
              beatCnt_q <= '0;
              state_q   <= last_q ? DRAIN : IDLE;
            end else begin
              wordCnt_q <= wordCnt_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (pop && (beatCnt_q == LAST_ADDR)) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stage 1 of the accumulate pipeline: the RAM word read for this address
  // has just arrived, so either overwrite (first channel) or add with
  // per-lane saturation.
  always_comb begin
    wrData_d = '0;
    for (int l = 0; l < LANES; l++) begin
      if (s1First_q) begin
        wrData_d[l*PSUM_W +: PSUM_W] = s1Data_q[l*PSUM_W +: PSUM_W];
      end else begin
        wrData_d[l*PSUM_W +: PSUM_W] = PSUM_W'(satAdd(
            32'(signed'(ramRdData[l*PSUM_W +: PSUM_W])),
            32'(signed'(s1Data_q[l*PSUM_W +: PSUM_W])),
            PSUM_W));
      end
    end
  end

  // Drain data is converted to pixels as it leaves the RAM, so the skid
  // buffer only ever holds finished output beats.
  always_comb begin
    pushData = '0;
    for (int l = 0; l < LANES; l++) begin
      pushData[l*PIX_W +: PIX_W] =
          reluShiftClamp(32'(signed'(ramRdData[l*PSUM_W +: PSUM_W])), OUT_SHIFT);
    end
  end

  // Two-entry skid buffer: entry 0 is the beat on the bus. A pop shifts
  // entry 1 forward, and an arriving read fills the first free slot after
  // that shift.
  always_comb begin
    occ_d   = occ_q;
    skid0_d = skid0_q;
    skid1_d = skid1_q;
    if (pop) begin
      skid0_d = skid1_q;
      occ_d   = occ_q - 2'd1;
    end
    if (push) begin
      if (occ_d == 2'd0) begin
        skid0_d = pushData;
      end else begin
        skid1_d = pushData;
      end
      occ_d = occ_d + 2'd1;
    end
  end

  // Control bits of the pipeline and skid buffer. These must clear on
  // reset so an aborted frame or drain cannot emit a stray write or beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid_q <= 1'b0;
      wrEn_q    <= 1'b0;
      rdPend_q  <= 1'b0;
      occ_q     <= 2'd0;
    end else begin
      s1Valid_q <= accept;
      wrEn_q    <= s1Valid_q;
      rdPend_q  <= readIssue;
      occ_q     <= occ_d;
    end
  end

  // Datapath registers that are only meaningful when their control bit is
  // set, so they carry no reset. The write lands two cycles after the input
  // word; the address two words later is the earliest one read again.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1Data_q  <= i_pe_data;
      s1Addr_q  <= wordCnt_q;
      s1First_q <= (state_q == IDLE) ? i_first_ic : first_q;
    end
    wrData_q <= wrData_d;
    wrAddr_q <= s1Addr_q;
    skid0_q  <= skid0_d;
    skid1_q  <= skid1_d;
  end

  assign m_axis_tvalid = (occ_q != 2'd0);
  assign m_axis_tdata  = skid0_q;
  assign m_axis_tstrb  = m_axis_tvalid ? 4'hF : 4'h0;
  assign m_axis_tlast  = m_axis_tvalid && (beatCnt_q == LAST_ADDR);
  assign o_busy        = (state_q != IDLE);
  assign o_done        = done_q;
  assign o_overflow    = overflow_q;

endmodule

// File: tb/tb_out_buffer.sv
// tb_out_buffer
//   Self-checking bench for out_buffer. Frames of PE words are driven with
//   random gaps; a frame-level model of the psum memory predicts every output
//   beat, and a bus monitor checks beats, tlast, tstrb and stability while
//   the stream is stalled.
module tb_out_buffer;

  localparam int FW = 768;

  logic        clk;
  logic        rst;
  logic        i_pe_valid;
  logic [63:0] i_pe_data;
  logic        i_first_ic;
  logic        i_last_ic;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tstrb;
  logic        m_axis_tlast;
  logic        o_busy;
  logic        o_done;
  logic        o_overflow;

  int testsRun  = 0;
  int failCount = 0;
  int doneCount = 0;
  int monBeat   = 0;

  int          model [FW][4];
  logic [32:0] expQ [$];

  bit          prevStall = 0;
  logic [31:0] prevData  = '0;
  logic        prevLast  = 1'b0;

  out_buffer dut (
    .clk           (clk),
    .rst           (rst),
    .i_pe_valid    (i_pe_valid),
    .i_pe_data     (i_pe_data),
    .i_first_ic    (i_first_ic),
    .i_last_ic     (i_last_ic),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tlast  (m_axis_tlast),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_overflow    (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single point through which every comparison is counted and reported.
  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change just after the rising edge, outputs are sampled on the
  // falling edge.
  task automatic stepToDrive();
    @(posedge clk);
    #1;
  endtask

  // Word generators for the different test patterns.
  function automatic logic [63:0] genWord(input int mode, input int k);
    logic [63:0] w;
    logic [15:0] kk;
    kk = 16'(k);
    case (mode)
      0: w = {kk, kk, kk, kk};
      1: w = {4{16'd100}};
      2: w = {16'h7000, 16'($urandom), 16'($urandom), 16'hFFCE};
      default: w = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
    endcase
    return w;
  endfunction

  // Drives one frame and updates the model: overwrite or saturating add per
  // lane, and when this is the last channel, queue the predicted beats.
  task automatic applyStimulus(input int mode, input bit first, input bit last,
                               input int gapPct);
    logic [63:0] w;
    logic [31:0] pixWord;
    int v;
    int s;
    int p;
    for (int k = 0; k < FW; k++) begin
      while ($urandom_range(0, 99) < gapPct) begin
        i_pe_valid = 1'b0;
        i_first_ic = 1'($urandom);
        i_last_ic  = 1'($urandom);
        stepToDrive();
      end
      w = genWord(mode, k);
      i_pe_valid = 1'b1;
      i_pe_data  = w;
      i_first_ic = (k == 0) ? first : 1'($urandom);
      i_last_ic  = (k == 0) ? last : 1'($urandom);
      for (int l = 0; l < 4; l++) begin
        v = int'($signed(w[l*16 +: 16]));
        if (first) begin
          model[k][l] = v;
        end else begin
          s = model[k][l] + v;
          if (s > 32767) s = 32767;
          if (s < -32768) s = -32768;
          model[k][l] = s;
        end
      end
      stepToDrive();
    end
    i_pe_valid = 1'b0;
    i_first_ic = 1'b0;
    i_last_ic  = 1'b0;
    if (last) begin
      for (int k = 0; k < FW; k++) begin
        pixWord = '0;
        for (int l = 0; l < 4; l++) begin
          p = (model[k][l] < 0) ? 0 : model[k][l] / 16;
          if (p > 255) p = 255;
          pixWord[l*8 +: 8] = 8'(p);
        end
        expQ.push_back({(k == FW - 1), pixWord});
      end
    end
  endtask

  // Runs the drain with the given tready duty. Optionally pulses i_pe_valid
  // three times mid-drain, or stops early once stopAtBeat beats were seen.
  task automatic drainFrame(input int readyPct, input bit ovfPulses,
                            input int stopAtBeat, input bit checkLat);
    int cyc = 0;
    int firstValid = 0;
    bit finished = 0;
    int prevDone;
    prevDone = doneCount;
    while (!finished && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) checkOutput("busy_in_drain", o_busy, 1);
      if (m_axis_tvalid && firstValid == 0) firstValid = cyc;
      if (o_done) finished = 1;
      if (stopAtBeat > 0 && monBeat >= stopAtBeat) finished = 1;
      stepToDrive();
      m_axis_tready = ($urandom_range(0, 99) < readyPct);
      i_pe_valid    = ovfPulses && (cyc == 20 || cyc == 40 || cyc == 60);
      i_pe_data     = {$urandom, $urandom};
      i_first_ic    = 1'($urandom);
      i_last_ic     = 1'($urandom);
    end
    i_pe_valid = 1'b0;
    i_first_ic = 1'b0;
    i_last_ic  = 1'b0;
    if (!finished) checkOutput("drain_timeout", {o_busy, o_done}, 2'b01);
    if (stopAtBeat == 0) begin
      m_axis_tready = 1'b1;
      repeat (5) @(negedge clk);
      checkOutput("done_pulses", doneCount, prevDone + 1);
      checkOutput("beats_left", expQ.size(), 0);
      checkOutput("busy_after_drain", o_busy, 0);
      if (checkLat) checkOutput("first_valid_latency", firstValid, 3);
      stepToDrive();
    end
  endtask

  // Bus monitor: scoreboards every handshake and checks that a stalled beat
  // is held unchanged.
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst) begin
      prevStall = 0;
      monBeat   = 0;
    end else begin
      if (o_done) doneCount++;
      if (prevStall) begin
        checkOutput("hold_valid", m_axis_tvalid, 1);
        checkOutput("hold_data", m_axis_tdata, prevData);
        checkOutput("hold_last", m_axis_tlast, prevLast);
      end
      if (m_axis_tvalid) checkOutput("tstrb", m_axis_tstrb, 4'hF);
      if (m_axis_tvalid && m_axis_tready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_beat", {m_axis_tvalid, m_axis_tready}, 2'b00);
        end else begin
          e = expQ.pop_front();
          checkOutput("tdata", m_axis_tdata, e[31:0]);
          checkOutput("tlast", m_axis_tlast, e[32]);
          monBeat++;
          if (e[32]) monBeat = 0;
        end
      end
      prevStall = m_axis_tvalid && !m_axis_tready;
      prevData  = m_axis_tdata;
      prevLast  = m_axis_tlast;
    end
  end

  initial begin
    rst           = 1'b1;
    i_pe_valid    = 1'b0;
    i_pe_data     = '0;
    i_first_ic    = 1'b0;
    i_last_ic     = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    checkOutput("reset_tvalid", m_axis_tvalid, 0);
    checkOutput("reset_tstrb", m_axis_tstrb, 0);
    checkOutput("reset_tlast", m_axis_tlast, 0);
    checkOutput("reset_busy", o_busy, 0);
    checkOutput("reset_done", o_done, 0);
    checkOutput("reset_overflow", o_overflow, 0);
    stepToDrive();

    $display("[TB] single-channel ramp frame");
    applyStimulus(0, 1, 1, 0);
    drainFrame(100, 0, 0, 1);

    $display("[TB] three-channel accumulation");
    for (int ic = 0; ic < 3; ic++) begin
      applyStimulus(1, ic == 0, ic == 2, 10);
      if (ic < 2) begin
        @(negedge clk);
        checkOutput("idle_after_ic", o_busy, 0);
        checkOutput("no_valid_after_ic", m_axis_tvalid, 0);
        stepToDrive();
      end
    end
    drainFrame(100, 0, 0, 1);

    $display("[TB] saturation and relu");
    applyStimulus(2, 1, 0, 5);
    applyStimulus(2, 0, 1, 5);
    drainFrame(100, 0, 0, 1);

    $display("[TB] backpressure with random data");
    applyStimulus(3, 1, 0, 20);
    applyStimulus(3, 0, 1, 20);
    drainFrame(30, 0, 0, 1);

    $display("[TB] overflow during drain");
    @(negedge clk);
    checkOutput("overflow_before", o_overflow, 0);
    stepToDrive();
    applyStimulus(3, 1, 1, 0);
    drainFrame(70, 1, 0, 0);
    @(negedge clk);
    checkOutput("overflow_sticky", o_overflow, 1);
    stepToDrive();

    $display("[TB] reset in the middle of a drain");
    applyStimulus(3, 1, 1, 0);
    drainFrame(100, 0, 100, 0);
    rst = 1'b1;
    stepToDrive();
    rst = 1'b0;
    expQ.delete();
    @(negedge clk);
    checkOutput("abort_tvalid", m_axis_tvalid, 0);
    checkOutput("abort_busy", o_busy, 0);
    checkOutput("abort_overflow", o_overflow, 0);
    stepToDrive();
    applyStimulus(3, 1, 1, 5);
    drainFrame(100, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/out_buffer.md
Name: out_buffer

Overview:
- Downstream stage of the convolution datapath: consumes the PE array's 4-lane partial-sum words, produced one per valid cycle over a 48-pixel x 16-row-group frame (768 words).
- Accumulates the partial sums across input channels in an on-chip psum RAM.
- After the last input channel, applies ReLU, shift and 8-bit clamp, then streams the frame to the DMA S2MM port as a 32-bit AXI-Stream master with tlast on the final beat.

Parameters:
FRAME_WORDS, 768, words per frame (48 pixels x 16 row groups)
ADDR_W, 10, psum RAM address width (2^ADDR_W >= FRAME_WORDS)
PSUM_W, 16, signed partial-sum width per lane
OUT_SHIFT, 4, right shift applied after ReLU before the 8-bit clamp

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous reset, active-high
i_pe_valid  in  1  one PE result word this cycle; no backpressure
i_pe_data  in  4*PSUM_W  lane3=[63:48] (top row of group) .. lane0=[15:0], signed
i_first_ic  in  1  sampled with a frame's first word: overwrite psums instead of accumulating
i_last_ic  in  1  sampled with a frame's first word: drain after this frame
m_axis_tvalid  out  1  output beat valid
m_axis_tready  in  1  DMA ready
m_axis_tdata  out  32  lane3 -> [31:24] .. lane0 -> [7:0], unsigned 8-bit pixels
m_axis_tstrb  out  4  constant 4'hF while tvalid is high, else 0
m_axis_tlast  out  1  high on beat FRAME_WORDS only
o_busy  out  1  state != IDLE
o_done  out  1  one-cycle pulse after the final beat handshakes
o_overflow  out  1  sticky: i_pe_valid arrived while in DRAIN; cleared only by rst

Behaviour:
- Reset values:
  - All outputs are 0, state is IDLE and all counters are 0.
  - RAM contents are don't-care.
  - Reset mid-frame or mid-drain aborts immediately; the next frame must be a first-ic frame.
- FSM IDLE / ACCUM / DRAIN:
  - IDLE -> ACCUM on i_pe_valid. That word is processed as word 0, and i_first_ic and i_last_ic are latched into first_q and last_q.
  - In ACCUM, each valid increments word_cnt.
  - On a valid with word_cnt == FRAME_WORDS-1, word_cnt wraps to 0. If last_q, go to DRAIN; otherwise go to IDLE.
  - In DRAIN, the FSM returns to IDLE in the cycle after the tlast handshake, and o_done pulses in that same cycle.
- Accumulate pipeline (ACCUM), 2 stages:
  - Stage 0: read RAM at word_cnt and register the input.
  - Stage 1: compute per lane: if first_q, sum = input; otherwise sum = RAM + input. The add saturates to the signed PSUM_W range (0x7FFF / 0x8000 for 16-bit).
  - Write occurs 2 cycles after the input valid.
  - Consecutive addresses never collide, so no forwarding is needed.
  - Gaps in i_pe_valid are allowed and hold the counters.
- Drain (DRAIN):
  - Reads RAM sequentially with 1-cycle read latency into a 2-entry skid buffer.
  - First tvalid appears 2 cycles after entering DRAIN.
  - With tready held high, one beat per cycle, FRAME_WORDS beats in total.
  - While tvalid && !tready, tdata, tlast and tvalid are held stable.
  - The read address advances only when skid space exists, so no beat is lost or duplicated.
- Output transform per lane: out = min((max(sum,0) >> OUT_SHIFT), 255).
- i_pe_valid while in DRAIN: the word is dropped and o_overflow is set. i_pe_valid while in IDLE always starts a frame.
- Width rules:
  - word_cnt and the drain address are ADDR_W bits.
  - tlast is generated from a separate beat counter compared to FRAME_WORDS-1 at handshake.

Decomposition:
- Package out_buffer_pkg holds:
  - the state enum (IDLE=2'd0, ACCUM=2'd1, DRAIN=2'd2);
  - LANES=4, FRAME_WORDS_DEF=768 and PIX_W=8;
  - a saturating-add function;
  - a ReLU/shift/clamp function.
- One sub-module, psum_ram: simple dual-port synchronous RAM with 1 write port, 1 read port, registered read, depth 2^ADDR_W, width 4*PSUM_W.

Test Plan:
- Single-ic frame (first=1, last=1), every lane of word k = k[9:0], tready=1.
  - Required: 768 beats; beat k lane = min(k>>4,255), so beat 767 = 8'h2F in every lane.
  - tlast only on beat 767; o_done pulses once.
- Three-ic accumulation (first on ic0, last on ic2), every lane = 16'd100 each frame.
  - Required: every lane = 300>>4 = 8'd18; no output traffic after ic0 or ic1.
- Saturation and ReLU.
  - Lane3 = 16'h7000 for two ics: saturates to 0x7FFF -> 8'd255.
  - Lane0 = -16'd50 for both ics: output 8'd0.
- Backpressure: random tready at 30% duty, known pattern.
  - Required: exact 768-beat sequence, no drops or duplicates.
  - tdata stable while tvalid && !tready.
- Overflow: pulse i_pe_valid 3 times during DRAIN.
  - Required: o_overflow=1 and sticky; output stream unchanged.
- Reset mid-drain at beat 100.
  - Required: next cycle tvalid=0, o_busy=0, o_overflow=0; a following single-ic frame streams correctly.
